// File: rtl/issue_fust_pkg.sv
// Shared types and constants for the issue-side functional-unit status table.
// The optional perf counters in issue_fust are enabled by FUST_PERF_EN.
package issue_fust_pkg;

   localparam int unsigned NUM_FU = 4;
   localparam int unsigned OP_W   = 5;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned TAG_W  = $clog2(NUM_FU + 1);

   // Tag 0 means the operand is available; tag k names FU k-1 as producer.
   localparam logic [TAG_W-1:0] TAG_READY = '0;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      WAIT   = 2'd1,
      READY  = 2'd2,
      ISSUED = 2'd3
   } fust_state_t;

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [TAG_W-1:0] t1;
      logic [TAG_W-1:0] t2;
   } fust_row_t;

   function automatic logic [TAG_W-1:0] tag_after_wb(
      input logic [TAG_W-1:0] tag,
      input logic             wb_valid,
      input logic [TAG_W-1:0] wb_tag
   );
      return (wb_valid && (tag == wb_tag)) ? TAG_READY : tag;
   endfunction

endpackage

// File: rtl/issue_fust_if.sv
// Dispatch <-> FUST link: row writes flow to the table, registered status
// (busy and current producer tags) flows back for hazard checks.
interface issue_fust_if #(
   parameter int unsigned NUM_FU = 4,
   parameter int unsigned OP_W   = 5,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned TAG_W  = $clog2(NUM_FU + 1),
   parameter int unsigned FU_W   = $clog2(NUM_FU)
);

   logic                    di_en;
   logic [FU_W-1:0]         di_fu;
   logic [OP_W-1:0]         di_op;
   logic [REG_W-1:0]        di_rd;
   logic [REG_W-1:0]        di_rs1;
   logic [REG_W-1:0]        di_rs2;
   logic [TAG_W-1:0]        di_t1;
   logic [TAG_W-1:0]        di_t2;

   logic [NUM_FU-1:0]       busy;
   logic [NUM_FU*TAG_W-1:0] row_t1;
   logic [NUM_FU*TAG_W-1:0] row_t2;

   modport master (
      output di_en, di_fu, di_op, di_rd, di_rs1, di_rs2, di_t1, di_t2,
      input  busy, row_t1, row_t2
   );

   modport slave (
      input  di_en, di_fu, di_op, di_rd, di_rs1, di_rs2, di_t1, di_t2,
      output busy, row_t1, row_t2
   );

endinterface

// File: rtl/issue_fust_row.sv
// One FUST row: state register, writeback tag clearing and issue condition.
module fust_row
   import issue_fust_pkg::*;
#(
   parameter int unsigned ROW_ID = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  fust_row_t        wr_row,
   input  logic             flush,
   input  logic             freeze,
   input  logic             wb_valid,
   input  logic [TAG_W-1:0] wb_tag,
   input  logic             fu_ready,
   output fust_state_t      state,
   output fust_row_t        row,
   output logic             issue
);

   localparam logic [TAG_W-1:0] MY_TAG = TAG_W'(ROW_ID + 1);

   fust_state_t      state_nx;
   fust_row_t        row_nx;
   logic [TAG_W-1:0] t1_clr;
   logic [TAG_W-1:0] t2_clr;

   always_comb begin
      issue    = (state == READY) && fu_ready && !freeze && !flush;
      state_nx = state;
      row_nx   = row;
      t1_clr   = tag_after_wb(row.t1, wb_valid, wb_tag);
      t2_clr   = tag_after_wb(row.t2, wb_valid, wb_tag);
      row_nx.t1 = t1_clr;
      row_nx.t2 = t2_clr;

      case (state)
         FREE: begin
            if (wr_en) begin
               // Incoming tags are bypassed against this cycle's writeback.
               row_nx    = wr_row;
               row_nx.t1 = tag_after_wb(wr_row.t1, wb_valid, wb_tag);
               row_nx.t2 = tag_after_wb(wr_row.t2, wb_valid, wb_tag);
               state_nx  = ((row_nx.t1 == TAG_READY) && (row_nx.t2 == TAG_READY))
                           ? READY : WAIT;
            end
         end
         WAIT: begin
            if (flush) begin
               state_nx  = FREE;
               row_nx.t1 = TAG_READY;
               row_nx.t2 = TAG_READY;
            end else if ((t1_clr == TAG_READY) && (t2_clr == TAG_READY)) begin
               state_nx = READY;
            end
         end
         READY: begin
            if (flush) begin
               state_nx = FREE;
            end else if (issue) begin
               state_nx = ISSUED;
            end
         end
         ISSUED: begin
            // Only the row's own completion frees it; flush leaves it in flight.
            if (wb_valid && (wb_tag == MY_TAG)) begin
               state_nx = FREE;
            end
         end
         default: state_nx = FREE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FREE;
         row   <= '0;
      end else begin
         state <= state_nx;
         row   <= row_nx;
      end
   end

endmodule

// File: rtl/issue_fust.sv
// Functional-unit status table: write decode, flush/freeze gating, wr_err and
// per-row instances. Define FUST_PERF_EN to add the issue/stall perf counters.
module issue_fust #(
   parameter int unsigned NUM_FU = issue_fust_pkg::NUM_FU,
   parameter int unsigned OP_W   = issue_fust_pkg::OP_W,
   parameter int unsigned REG_W  = issue_fust_pkg::REG_W,
   parameter int unsigned TAG_W  = $clog2(NUM_FU + 1)
) (
   input  logic                    CLK,
   input  logic                    nRST,
   issue_fust_if.slave             dsp,
   input  logic                    flush,
   input  logic                    freeze,
   input  logic                    wb_valid,
   input  logic [TAG_W-1:0]        wb_tag,
   input  logic [NUM_FU-1:0]       fu_ready,
   output logic [NUM_FU-1:0]       issue_valid,
   output logic [NUM_FU*OP_W-1:0]  issue_op,
   output logic [NUM_FU*REG_W-1:0] issue_rd,
   output logic [NUM_FU*REG_W-1:0] issue_rs1,
   output logic [NUM_FU*REG_W-1:0] issue_rs2,
`ifdef FUST_PERF_EN
   output logic [31:0]             perf_issue_cnt,
   output logic [31:0]             perf_stall_cnt,
`endif
   output logic                    wr_err
);

   import issue_fust_pkg::*;

   localparam int unsigned FU_W = $clog2(NUM_FU);

   logic              wr_ok;
   logic [NUM_FU-1:0] row_free;
   logic [NUM_FU-1:0] row_wr;
   fust_row_t         wr_row;
   fust_state_t       st  [NUM_FU];
   fust_row_t         row [NUM_FU];

   assign wr_ok = dsp.di_en && !freeze && !flush;

   always_comb begin
      wr_row     = '0;
      wr_row.op  = dsp.di_op;
      wr_row.rd  = dsp.di_rd;
      wr_row.rs1 = dsp.di_rs1;
      wr_row.rs2 = dsp.di_rs2;
      wr_row.t1  = dsp.di_t1;
      wr_row.t2  = dsp.di_t2;
   end

   for (genvar i = 0; i < NUM_FU; i++) begin : g_row
      assign row_wr[i] = wr_ok && (dsp.di_fu == FU_W'(i)) && row_free[i];

      fust_row #(
         .ROW_ID (i)
      ) u_row (
         .clk      (CLK),
         .rst_n    (nRST),
         .wr_en    (row_wr[i]),
         .wr_row   (wr_row),
         .flush    (flush),
         .freeze   (freeze),
         .wb_valid (wb_valid),
         .wb_tag   (wb_tag),
         .fu_ready (fu_ready[i]),
         .state    (st[i]),
         .row      (row[i]),
         .issue    (issue_valid[i])
      );

      assign row_free[i]                  = (st[i] == FREE);
      assign dsp.busy[i]                  = !row_free[i];
      assign dsp.row_t1[i*TAG_W +: TAG_W] = row[i].t1;
      assign dsp.row_t2[i*TAG_W +: TAG_W] = row[i].t2;

      assign issue_op [i*OP_W  +: OP_W ] = row_free[i] ? '0 : row[i].op;
      assign issue_rd [i*REG_W +: REG_W] = row_free[i] ? '0 : row[i].rd;
      assign issue_rs1[i*REG_W +: REG_W] = row_free[i] ? '0 : row[i].rs1;
      assign issue_rs2[i*REG_W +: REG_W] = row_free[i] ? '0 : row[i].rs2;
   end

   // A write aimed at an occupied row is dropped; remember it until reset.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr_err <= 1'b0;
      end else if (wr_ok && !row_free[dsp.di_fu]) begin
         wr_err <= 1'b1;
      end
   end

`ifdef FUST_PERF_EN
   logic [NUM_FU-1:0] row_wait;
   logic [NUM_FU-1:0] row_ready;
   logic              stall_now;
   logic [32:0]       issue_sum;

   for (genvar i = 0; i < NUM_FU; i++) begin : g_perf
      assign row_wait[i]  = (st[i] == WAIT);
      assign row_ready[i] = (st[i] == READY);
   end

   assign stall_now = |(row_wait | (row_ready & ~fu_ready));
   assign issue_sum = {1'b0, perf_issue_cnt} + 33'($countones(issue_valid));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         perf_issue_cnt <= '0;
         perf_stall_cnt <= '0;
      end else if (!freeze) begin
         perf_issue_cnt <= issue_sum[32] ? '1 : issue_sum[31:0];
         if (stall_now && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_issue_fust.sv
// Scoreboard bench for issue_fust: directed scenarios plus random traffic,
// predicted by a row-occupancy model and checked by a decoupled monitor.
module tb_issue_fust;

   localparam int N  = 4;
   localparam int OW = 5;
   localparam int RW = 5;
   localparam int TW = 3;
   localparam int FW = 2;

   logic            CLK = 1'b0;
   logic            nRST = 1'b0;
   logic            flush = 1'b0;
   logic            freeze = 1'b0;
   logic            wb_valid = 1'b0;
   logic [TW-1:0]   wb_tag = '0;
   logic [N-1:0]    fu_ready = '0;
   logic [N-1:0]    issue_valid;
   logic [N*OW-1:0] issue_op;
   logic [N*RW-1:0] issue_rd, issue_rs1, issue_rs2;
   logic            wr_err;
`ifdef FUST_PERF_EN
   logic [31:0]     perf_issue_cnt, perf_stall_cnt;
`endif

   always #5 CLK = ~CLK;

   issue_fust_if #(.NUM_FU(N), .OP_W(OW), .REG_W(RW), .TAG_W(TW), .FU_W(FW)) dif ();

   issue_fust #(.NUM_FU(N), .OP_W(OW), .REG_W(RW), .TAG_W(TW)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .dsp         (dif.slave),
      .flush       (flush),
      .freeze      (freeze),
      .wb_valid    (wb_valid),
      .wb_tag      (wb_tag),
      .fu_ready    (fu_ready),
      .issue_valid (issue_valid),
      .issue_op    (issue_op),
      .issue_rd    (issue_rd),
      .issue_rs1   (issue_rs1),
      .issue_rs2   (issue_rs2),
`ifdef FUST_PERF_EN
      .perf_issue_cnt (perf_issue_cnt),
      .perf_stall_cnt (perf_stall_cnt),
`endif
      .wr_err      (wr_err)
   );

   // Model row: occupied / already sent to its FU, plus the latched fields.
   typedef struct packed {
      bit          occ;
      bit          iss;
      logic [OW-1:0] op;
      logic [RW-1:0] rd, rs1, rs2;
      logic [TW-1:0] t1, t2;
   } mrow_t;

   typedef struct {
      logic [N-1:0]    busy, iv;
      logic            err;
      logic [N*TW-1:0] t1, t2;
      logic [N*OW-1:0] op;
      logic [N*RW-1:0] rd, rs1, rs2;
      logic [31:0]     pi, ps;
   } exp_t;

   mrow_t   m [N];
   bit      m_err;
   longint  m_pi, m_ps;
   exp_t    q [$];
   int      checks = 0;
   int      errors = 0;

   bit            s_rst, s_fl, s_fr, s_de, s_wv;
   logic [FW-1:0] s_fu;
   logic [OW-1:0] s_op;
   logic [RW-1:0] s_rd, s_rs1, s_rs2;
   logic [TW-1:0] s_t1, s_t2, s_wt;
   logic [N-1:0]  s_rdy;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   task automatic defaults();
      s_rst = 1; s_fl = 0; s_fr = 0; s_de = 0; s_wv = 0;
      s_fu = '0; s_op = '0; s_rd = '0; s_rs1 = '0; s_rs2 = '0;
      s_t1 = '0; s_t2 = '0; s_wt = '0; s_rdy = '1;
   endtask

   // Drive one cycle's inputs, queue the expected outputs, advance the model.
   task automatic apply();
      exp_t  e;
      mrow_t nm [N];
      bit    stall;
      int    cnt;
      nRST = s_rst; flush = s_fl; freeze = s_fr; wb_valid = s_wv;
      wb_tag = s_wt; fu_ready = s_rdy;
      dif.di_en = s_de; dif.di_fu = s_fu; dif.di_op = s_op; dif.di_rd = s_rd;
      dif.di_rs1 = s_rs1; dif.di_rs2 = s_rs2; dif.di_t1 = s_t1; dif.di_t2 = s_t2;
      if (!s_rst) begin
         for (int i = 0; i < N; i++) m[i] = '0;
         m_err = 0; m_pi = 0; m_ps = 0;
      end
      stall = 0; cnt = 0;
      for (int i = 0; i < N; i++) begin
         e.iv[i] = m[i].occ && !m[i].iss && m[i].t1 == 0 && m[i].t2 == 0 &&
                   s_rdy[i] && !s_fr && !s_fl;
         e.busy[i] = m[i].occ;
         e.t1[i*TW +: TW] = m[i].t1;  e.t2[i*TW +: TW] = m[i].t2;
         e.op[i*OW +: OW] = m[i].op;  e.rd[i*RW +: RW] = m[i].rd;
         e.rs1[i*RW +: RW] = m[i].rs1; e.rs2[i*RW +: RW] = m[i].rs2;
         if (e.iv[i]) cnt++;
         if (m[i].occ && !m[i].iss && (m[i].t1 != 0 || m[i].t2 != 0 || !s_rdy[i]))
            stall = 1;
      end
      e.err = m_err; e.pi = 32'(m_pi); e.ps = 32'(m_ps);
      q.push_back(e);
      if (!s_rst) return;
      for (int i = 0; i < N; i++) begin
         nm[i] = m[i];
         if (m[i].occ) begin
            if (s_wv && m[i].t1 == s_wt) nm[i].t1 = 0;
            if (s_wv && m[i].t2 == s_wt) nm[i].t2 = 0;
            if (m[i].iss) begin
               if (s_wv && s_wt == TW'(i + 1)) begin nm[i].occ = 0; nm[i].iss = 0; end
            end else if (s_fl) begin
               nm[i].occ = 0; nm[i].t1 = 0; nm[i].t2 = 0;
            end else if (e.iv[i]) begin
               nm[i].iss = 1;
            end
         end else if (s_de && !s_fr && !s_fl && s_fu == FW'(i)) begin
            nm[i].occ = 1; nm[i].iss = 0;
            nm[i].op = s_op; nm[i].rd = s_rd; nm[i].rs1 = s_rs1; nm[i].rs2 = s_rs2;
            nm[i].t1 = (s_wv && s_t1 == s_wt) ? '0 : s_t1;
            nm[i].t2 = (s_wv && s_t2 == s_wt) ? '0 : s_t2;
         end
      end
      if (s_de && !s_fr && !s_fl && m[s_fu].occ) m_err = 1;
      if (!s_fr) begin
         m_pi = m_pi + cnt;
         if (m_pi > 64'hFFFF_FFFF) m_pi = 64'hFFFF_FFFF;
         if (stall && m_ps < 64'hFFFF_FFFF) m_ps++;
      end
      for (int i = 0; i < N; i++) m[i] = nm[i];
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   // Monitor: every cycle the DUT presents outputs, pop and compare.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("busy", dif.busy, e.busy);
            chk("issue_valid", issue_valid, e.iv);
            chk("wr_err", wr_err, e.err);
            for (int i = 0; i < N; i++) begin
               if (e.busy[i]) begin
                  chk($sformatf("row_t1[%0d]", i), dif.row_t1[i*TW +: TW], e.t1[i*TW +: TW]);
                  chk($sformatf("row_t2[%0d]", i), dif.row_t2[i*TW +: TW], e.t2[i*TW +: TW]);
                  chk($sformatf("issue_op[%0d]", i), issue_op[i*OW +: OW], e.op[i*OW +: OW]);
                  chk($sformatf("issue_rd[%0d]", i), issue_rd[i*RW +: RW], e.rd[i*RW +: RW]);
                  chk($sformatf("issue_rs1[%0d]", i), issue_rs1[i*RW +: RW], e.rs1[i*RW +: RW]);
                  chk($sformatf("issue_rs2[%0d]", i), issue_rs2[i*RW +: RW], e.rs2[i*RW +: RW]);
               end
            end
`ifdef FUST_PERF_EN
            chk("perf_issue_cnt", perf_issue_cnt, e.pi);
            chk("perf_stall_cnt", perf_stall_cnt, e.ps);
`endif
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      defaults();
      @(negedge CLK);
      s_rst = 0; apply(); #2;
      chk("reset busy", dif.busy, 0); chk("reset issue_valid", issue_valid, 0);
      chk("reset wr_err", wr_err, 0); chk("reset row_t1", dif.row_t1, 0);
      tick();
      // Ready-operand issue on row 0.
      defaults(); s_de = 1; s_fu = 0; s_op = 3; s_rd = 5; apply(); tick();
      defaults(); apply(); #2;
      chk("ready busy0", dif.busy[0], 1); chk("ready iv0", issue_valid[0], 1);
      chk("ready rd0", issue_rd[4:0], 5); chk("ready op0", issue_op[4:0], 3);
      tick();
      defaults(); apply(); #2;
      chk("issued iv0", issue_valid[0], 0); chk("issued busy0", dif.busy[0], 1);
      tick();
      // Dependency wake: row 2 waits on FU0.
      defaults(); s_de = 1; s_fu = 2; s_rd = 7; s_t1 = 1; apply(); tick();
      defaults(); s_wv = 1; s_wt = 1; apply(); #2;
      chk("wait iv2", issue_valid[2], 0); chk("wait t1_2", dif.row_t1[8:6], 1);
      tick();
      defaults(); apply(); #2;
      chk("wake iv2", issue_valid[2], 1); chk("wake t1_2", dif.row_t1[8:6], 0);
      chk("complete busy0", dif.busy[0], 0);
      tick();
      // Same-cycle bypass on t2.
      defaults(); s_de = 1; s_fu = 1; s_t2 = 3; s_wv = 1; s_wt = 3; apply(); tick();
      defaults(); apply(); #2;
      chk("bypass iv1", issue_valid[1], 1); chk("bypass t2_1", dif.row_t2[5:3], 0);
      tick();
      defaults(); s_wv = 1; s_wt = 2; apply(); tick();
      // Write to a READY row is dropped and flags wr_err.
      defaults(); s_rdy = 4'b1101; s_de = 1; s_fu = 1; s_op = 9; s_rd = 11; apply(); tick();
      defaults(); s_rdy = 4'b1101; s_de = 1; s_fu = 1; s_op = 1; s_rd = 1; apply(); #2;
      chk("busywr iv1", issue_valid[1], 0);
      tick();
      defaults(); s_rdy = 4'b1101; apply(); #2;
      chk("busywr err", wr_err, 1); chk("busywr op1", issue_op[9:5], 9);
      chk("busywr rd1", issue_rd[9:5], 11);
      tick();
      // Flush: READY row 1 dropped, ISSUED row 3 kept, write to row 2 suppressed.
      defaults(); s_rdy = 4'b1101; s_de = 1; s_fu = 3; s_op = 4; apply(); tick();
      defaults(); s_rdy = 4'b1101; apply(); #2;
      chk("flush pre iv3", issue_valid[3], 1);
      tick();
      defaults(); s_rdy = 4'b1101; s_fl = 1; s_de = 1; s_fu = 2; s_op = 6; apply(); #2;
      chk("flush iv", issue_valid, 0);
      tick();
      defaults(); apply(); #2;
      chk("flush busy", dif.busy, 4'b1000); chk("flush err sticky", wr_err, 1);
      tick();
      defaults(); s_wv = 1; s_wt = 4; apply(); tick();
      defaults(); apply(); #2;
      chk("flush done busy", dif.busy, 0);
      tick();
      // Freeze with writeback: tag clears, issue waits for freeze release.
      defaults(); s_de = 1; s_fu = 0; s_t1 = 2; apply(); tick();
      defaults(); s_fr = 1; s_wv = 1; s_wt = 2; apply(); #2;
      chk("freeze iv0 a", issue_valid[0], 0);
      tick();
      defaults(); s_fr = 1; apply(); #2;
      chk("freeze iv0 b", issue_valid[0], 0); chk("freeze t1_0", dif.row_t1[2:0], 0);
      tick();
      defaults(); apply(); #2;
      chk("thaw iv0", issue_valid[0], 1);
      tick();
      defaults(); s_rst = 0; apply(); #2;
      chk("rst clears err", wr_err, 0);
      tick();
      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         defaults();
         if (c % 600 == 599) s_rst = 0;
         s_fl  = ($urandom_range(19) == 0);
         s_fr  = ($urandom_range(6) == 0);
         s_de  = $urandom_range(1);
         s_fu  = FW'($urandom_range(N - 1));
         s_op  = OW'($urandom); s_rd = RW'($urandom);
         s_rs1 = RW'($urandom); s_rs2 = RW'($urandom);
         s_t1  = ($urandom_range(2) == 0) ? TW'($urandom_range(N)) : '0;
         s_t2  = ($urandom_range(2) == 0) ? TW'($urandom_range(N)) : '0;
         s_wv  = ($urandom_range(2) != 0);
         s_wt  = TW'($urandom_range(N, 1));
         s_rdy = N'($urandom);
         apply();
         tick();
      end
      defaults(); apply(); tick();
      for (int k = 0; k < 10 && q.size() != 0; k++) tick();
      if (q.size() != 0) chk("scoreboard drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
